key_debounce: RTL and testbench

// - Input-side counterpart of the LED driver: samples KEY_NUM mechanical push-buttons on the board.
// - Synchronises each key to sys_clk and removes contact bounce.
// - Presents a stable level per key, plus one-cycle press and release strobes.
// - Sits between the top-level key pins and user logic, e.g. LED toggle control or mode select.

---
 rtl/key_debounce_if.sv | 20 ++
 rtl/key_debounce.sv | 151 +++++++++++++++
 tb/tb_key_debounce.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key pin / debounced-event bundle between the board pins, key_debounce and user logic.
interface key_debounce_if #(
  parameter int unsigned KEY_NUM = 4
);
  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;

  modport master (
    output key_in,
    input  key_state, key_press, key_release, key_long
  );

  modport slave (
    input  key_in,
    output key_state, key_press, key_release, key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser + debounce FSM giving a stable level and press/release strobes.
// Optional long-press strobe is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
  parameter int unsigned KEY_NUM        = 4,
  parameter int unsigned CLK_FREQ       = 200_000_000,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned LONG_MS        = 1000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  key_debounce_if.slave  kif
);

  localparam int unsigned DB_CYC = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DB_W   = $clog2(DB_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYC - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    PRESSED,
    RELEASE_CHK
  } key_st_e;

  logic [KEY_NUM-1:0] sync1_q;
  logic [KEY_NUM-1:0] sync2_q;
  logic [KEY_NUM-1:0] pressed;

  // Sync flops reset to the released pin level so reset release never looks like a press.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= KEY_ACTIVE_LOW ? '1 : '0;
      sync2_q <= KEY_ACTIVE_LOW ? '1 : '0;
    end else begin
      sync1_q <= kif.key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_st_e         st_q;
    logic [DB_W-1:0] cnt_q;
    logic            lvl_q;
    logic            prs_q;
    logic            rls_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= RELEASED;
        cnt_q <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rls_q <= 1'b0;
      end else begin
        prs_q <= 1'b0;
        rls_q <= 1'b0;
        case (st_q)
          RELEASED: begin
            if (pressed[g]) begin
              st_q  <= PRESS_CHK;
              cnt_q <= '0;
            end
          end
          PRESS_CHK: begin
            if (!pressed[g]) begin
              st_q  <= RELEASED;
              cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
              st_q  <= PRESSED;
              cnt_q <= '0;
              lvl_q <= 1'b1;
              prs_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (!pressed[g]) begin
              st_q  <= RELEASE_CHK;
              cnt_q <= '0;
            end
          end
          RELEASE_CHK: begin
            if (pressed[g]) begin
              st_q  <= PRESSED;
              cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
              st_q  <= RELEASED;
              cnt_q <= '0;
              lvl_q <= 1'b0;
              rls_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            st_q  <= RELEASED;
            cnt_q <= '0;
          end
        endcase
      end
    end

    assign kif.key_state[g]   = lvl_q;
    assign kif.key_press[g]   = prs_q;
    assign kif.key_release[g] = rls_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LONG_CYC = CLK_FREQ / 1000 * LONG_MS;
    localparam int unsigned LONG_W   = $clog2(LONG_CYC + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

    logic [LONG_W-1:0] lcnt_q;
    logic              ldone_q;
    logic              lng_q;

    // Clearing throughout PRESS_CHK equals clearing on entry to PRESSED from it,
    // since PRESSED is only reachable from PRESS_CHK or RELEASE_CHK.
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        lcnt_q  <= '0;
        ldone_q <= 1'b0;
        lng_q   <= 1'b0;
      end else begin
        lng_q <= 1'b0;
        if (st_q == PRESS_CHK) begin
          lcnt_q  <= '0;
          ldone_q <= 1'b0;
        end else if (st_q == PRESSED || st_q == RELEASE_CHK) begin
          if (lcnt_q == LONG_LAST) begin
            if (!ldone_q) begin
              lng_q   <= 1'b1;
              ldone_q <= 1'b1;
            end
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
      end
    end

    assign kif.key_long[g] = lng_q;
`else
    assign kif.key_long[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed, table-driven bench for key_debounce with scaled-down timing (DB_CYC=100, LONG_CYC=500).
module tb_key_debounce;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;

  always #5 sys_clk = ~sys_clk;

  key_debounce_if #(.KEY_NUM(4)) kif ();

  key_debounce #(
    .KEY_NUM       (4),
    .CLK_FREQ      (100_000),
    .DEBOUNCE_MS   (1),
    .LONG_MS       (5),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .kif     (kif)
  );

  typedef struct {
    logic [3:0] key;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] state;
  } vec_t;

  vec_t tbl [7];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Steps n posedges; k counts from 0 at the first edge after the inputs were driven.
  // Strobes are captured at k==tgt (press/release) and k==ltgt (long); any other strobe,
  // or press and release together on one bit, counts as stray.
  task automatic watch(input int n, input int tgt, input int ltgt,
                       output logic [3:0] p_at, output logic [3:0] r_at,
                       output logic [3:0] l_at, output int stray);
    p_at = '0; r_at = '0; l_at = '0; stray = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge sys_clk); #1;
      if ((kif.key_press & kif.key_release) != 4'b0) stray++;
      if (k == tgt) begin
        p_at = kif.key_press;
        r_at = kif.key_release;
      end else if ((kif.key_press | kif.key_release) != 4'b0) begin
        stray++;
      end
      if (k == ltgt) l_at = kif.key_long;
      else if (kif.key_long != 4'b0) stray++;
    end
  endtask

  logic [3:0] p, r, l;
  int         s, acc, bad_rst;
  logic [3:0] exp_long;

  initial begin
    tbl[0] = '{key: 4'b1110, press: 4'b0001, rel: 4'b0000, state: 4'b0001};
    tbl[1] = '{key: 4'b1111, press: 4'b0000, rel: 4'b0001, state: 4'b0000};
    tbl[2] = '{key: 4'b0000, press: 4'b1111, rel: 4'b0000, state: 4'b1111};
    tbl[3] = '{key: 4'b1111, press: 4'b0000, rel: 4'b1111, state: 4'b0000};
    tbl[4] = '{key: 4'b1010, press: 4'b0101, rel: 4'b0000, state: 4'b0101};
    tbl[5] = '{key: 4'b0110, press: 4'b1000, rel: 4'b0100, state: 4'b1001};
    tbl[6] = '{key: 4'b1111, press: 4'b0000, rel: 4'b1001, state: 4'b0000};

`ifdef KEY_LONG_PRESS_EN
    exp_long = 4'b1000;
`else
    exp_long = 4'b0000;
`endif

    kif.key_in = 4'b1111;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_outputs", {16'b0, kif.key_state, kif.key_press, kif.key_release, kif.key_long}, 32'h0);
    rst_n = 1'b1;
    watch(20, -1, -1, p, r, l, s);
    check("idle_stray", s, 0);

    for (int i = 0; i < 7; i++) begin
      kif.key_in = tbl[i].key;
      watch(200, 102, -1, p, r, l, s);
      check($sformatf("vec%0d_press", i), {28'b0, p}, {28'b0, tbl[i].press});
      check($sformatf("vec%0d_release", i), {28'b0, r}, {28'b0, tbl[i].rel});
      check($sformatf("vec%0d_state", i), {28'b0, kif.key_state}, {28'b0, tbl[i].state});
      check($sformatf("vec%0d_stray", i), s, 0);
    end

    // Bounce on key 1: ten 30-cycle phases, then held low from the last edge.
    acc = 0;
    for (int t = 0; t < 10; t++) begin
      kif.key_in = (t % 2 == 0) ? 4'b1101 : 4'b1111;
      watch(30, -1, -1, p, r, l, s);
      acc += s;
    end
    check("bounce_no_strobe", acc, 0);
    kif.key_in = 4'b1101;
    watch(200, 102, -1, p, r, l, s);
    check("bounce_press", {28'b0, p}, 32'h2);
    check("bounce_release", {28'b0, r}, 32'h0);
    check("bounce_stray", s, 0);
    kif.key_in = 4'b1111;
    watch(200, 102, -1, p, r, l, s);
    check("bounce_final_release", {28'b0, r}, 32'h2);

    // Reset while key 2 is mid-qualification (cnt=60) and key 0 is already pressed.
    kif.key_in = 4'b1110;
    watch(150, 102, -1, p, r, l, s);
    check("rst_pre_press", {28'b0, p}, 32'h1);
    kif.key_in = 4'b1010;
    watch(63, -1, -1, p, r, l, s);
    check("rst_pre_stray", s, 0);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", {28'b0, kif.key_state}, 32'h0);
    bad_rst = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge sys_clk); #1;
      if ({kif.key_state, kif.key_press, kif.key_release, kif.key_long} != 16'h0) bad_rst++;
    end
    check("rst_hold_outputs", bad_rst, 0);
    rst_n = 1'b1;
    watch(200, 102, -1, p, r, l, s);
    check("rst_after_press", {28'b0, p}, 32'h5);
    check("rst_after_state", {28'b0, kif.key_state}, 32'h5);
    check("rst_after_stray", s, 0);

    // Release of key 0 with a 50-cycle low glitch during RELEASE_CHK.
    kif.key_in = 4'b1011;
    watch(40, -1, -1, p, r, l, s);
    acc = s;
    kif.key_in = 4'b1010;
    watch(50, -1, -1, p, r, l, s);
    acc += s;
    check("glitch_no_strobe", acc, 0);
    kif.key_in = 4'b1011;
    watch(200, 102, -1, p, r, l, s);
    check("glitch_release", {28'b0, r}, 32'h1);
    check("glitch_state", {28'b0, kif.key_state}, 32'h4);
    check("glitch_stray", s, 0);
    kif.key_in = 4'b1111;
    watch(200, 102, -1, p, r, l, s);
    check("key2_release", {28'b0, r}, 32'h4);

    // Long hold on key 3: press at k=102, long strobe 500 cycles after entering PRESSED.
    kif.key_in = 4'b0111;
    watch(1102, 102, 602, p, r, l, s);
    check("long_press", {28'b0, p}, 32'h8);
    check("long_strobe", {28'b0, l}, {28'b0, exp_long});
    check("long_stray", s, 0);
    kif.key_in = 4'b1111;
    watch(200, 102, -1, p, r, l, s);
    check("long_release", {28'b0, r}, 32'h8);
    check("long_release_stray", s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
